sysarr_ctrl: RTL
================

SYSARR_CTRL -- requirements
Module: sysarr_ctrl

Interface
REQ-001 Parameter N, default 31: word MSB index; word width is N+1 bits.
REQ-002 Parameter n, default 4: array dimension (n x n operands).
REQ-003 Parameter DRAIN_CYC, default 2*n: cycles flg is held at n before result capture.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request a multiply; accepted only in IDLE.
REQ-007 op_a  in  (N+1)*n*n  matrix A; slice k = bits [(k+1)*(N+1)*n-1 : k*(N+1)*n].
REQ-008 op_b  in  (N+1)*n*n  matrix B; same slicing as op_a.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 flg  out  7  step index to the systolic array.
REQ-011 arr1, arr2  out  (N+1)*n each  operand slice to the array.
REQ-012 row_in  in  (N+1)*n  array outrow; col_in  in  (N+1)*(n-1)  array outcolumn.
REQ-013 res_row  out  (N+1)*n; res_col  out  (N+1)*(n-1)  captured results.
REQ-014 res_valid  out  1; res_ready  in  1  result handshake.

Function
REQ-015 States: IDLE, LOAD, DRAIN, CAPTURE, HOLD; all outputs registered.
REQ-016 IDLE: flg = n, arr1 = arr2 = 0; start=1 latches op_a/op_b into internal buffers and moves to LOAD.
REQ-017 LOAD lasts exactly n cycles; in LOAD cycle k (0..n-1): flg = k, arr1 = buffered A slice k, arr2 = buffered B slice k.
REQ-018 After LOAD cycle n-1: DRAIN; flg = n, arr1 = arr2 = 0 for exactly DRAIN_CYC cycles (down-counter).
REQ-019 CAPTURE (1 cycle): res_row <= row_in, res_col <= col_in; next state HOLD.
REQ-020 HOLD: res_valid = 1; res_row/res_col stable; on res_valid & res_ready go to IDLE, res_valid drops the next cycle.
REQ-021 Latency: start sampled at edge T -> first LOAD cycle begins T; res_valid high from edge T+n+DRAIN_CYC+1 (13 cycles at defaults).
REQ-022 start outside IDLE is ignored; op_a/op_b changes after acceptance have no effect.
REQ-023 start and res_ready both high in HOLD: handshake completes to IDLE; start in that same cycle is ignored.
REQ-024 res_ready without res_valid has no effect.
REQ-025 flg never exceeds n; flg = 0 occurs exactly once per operation.
REQ-026 Counter widths: step counter ceil(log2(n+1)) bits, drain counter ceil(log2(DRAIN_CYC+1)) bits; no wrap permitted.

Reset
REQ-027 rst=1 forces IDLE asynchronously: flg = n, arr1 = arr2 = 0, busy = 0, res_valid = 0, res_row = res_col = 0, buffers = 0.
REQ-028 rst mid-operation abandons the operation; no res_valid is produced for it.
REQ-029 After rst deasserts, first start is accepted on the next edge.

Structure
REQ-030 Package sysarr_pkg holds N, n defaults, DRAIN_CYC default, and the state enum typedef.
REQ-031 No sub-module is required; the operand buffers and slice mux stay inline.
REQ-032 The block instantiates nothing from the array; it connects to it at the top level only.

Verification
REQ-033 start with A = identity, B = [1..16] row-major -> flg sequence 0,1,2,3 then 4 x8, res_valid at start+13, res_row = array row_in at capture.
REQ-034 start held high continuously -> exactly one operation per IDLE visit; busy never drops mid-operation.
REQ-035 res_ready = 0 for 20 cycles in HOLD -> res_valid and res_row/res_col stable throughout; ready=1 -> IDLE next cycle.
REQ-036 rst asserted during DRAIN cycle 3 -> immediate flg = 4, busy = 0, res_valid = 0; subsequent start completes normally.
REQ-037 op_a changed to all 0xFFFFFFFF one cycle after start -> arr1 still carries originally latched slices.
REQ-038 start in same cycle as HOLD handshake -> ignored; new start next cycle accepted.

Source files
------------

// File: rtl/sysarr_pkg.sv
// Shared defaults and state encoding for the systolic-array operand sequencer.
package sysarr_pkg;

    localparam int DEF_N         = 31;
    localparam int DEF_DIM       = 4;
    localparam int DEF_DRAIN_CYC = 2 * DEF_DIM;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        CAPTURE,
        HOLD
    } state_t;

endpackage

// File: rtl/sysarr_ctrl_if.sv
// Host-side request/result bundle for sysarr_ctrl; the host is master, the controller is slave.
interface sysarr_ctrl_if #(
    parameter int N = sysarr_pkg::DEF_N,
    parameter int n = sysarr_pkg::DEF_DIM
) ();

    logic                       start;
    logic [(N+1)*n*n-1:0]       op_a;
    logic [(N+1)*n*n-1:0]       op_b;
    logic                       busy;
    logic [(N+1)*n-1:0]         res_row;
    logic [(N+1)*(n-1)-1:0]     res_col;
    logic                       res_valid;
    logic                       res_ready;

    modport master (
        output start, op_a, op_b, res_ready,
        input  busy, res_row, res_col, res_valid
    );

    modport slave (
        input  start, op_a, op_b, res_ready,
        output busy, res_row, res_col, res_valid
    );

endinterface

// File: rtl/sysarr_ctrl.sv
// Sequencer that streams buffered operand slices into an n x n systolic array,
// waits for it to drain, then captures and holds the result until the host accepts it.
module sysarr_ctrl
    import sysarr_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int n         = DEF_DIM,
    parameter int DRAIN_CYC = 2 * n
) (
    input  logic                   clk,
    input  logic                   rst,
    sysarr_ctrl_if.slave           bus,
    output logic [6:0]             flg,
    output logic [(N+1)*n-1:0]     arr1,
    output logic [(N+1)*n-1:0]     arr2,
    input  logic [(N+1)*n-1:0]     row_in,
    input  logic [(N+1)*(n-1)-1:0] col_in
);

    localparam int SW      = (N + 1) * n;
    localparam int STEP_W  = $clog2(n + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    state_t               state;
    logic [SW*n-1:0]      buf_a;
    logic [SW*n-1:0]      buf_b;
    logic [STEP_W-1:0]    step;
    logic [DRAIN_W-1:0]   drain;

    // Slice 0 goes out on the accepting edge straight from the inputs, so
    // step already points at the next slice once LOAD is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            buf_a         <= '0;
            buf_b         <= '0;
            step          <= '0;
            drain         <= '0;
            flg           <= 7'(n);
            arr1          <= '0;
            arr2          <= '0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_row   <= '0;
            bus.res_col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        buf_a    <= bus.op_a;
                        buf_b    <= bus.op_b;
                        flg      <= 7'd0;
                        arr1     <= bus.op_a[SW-1:0];
                        arr2     <= bus.op_b[SW-1:0];
                        step     <= STEP_W'(1);
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (step == STEP_W'(n)) begin
                        flg   <= 7'(n);
                        arr1  <= '0;
                        arr2  <= '0;
                        drain <= DRAIN_W'(DRAIN_CYC - 1);
                        state <= DRAIN;
                    end else begin
                        flg  <= 7'(step);
                        arr1 <= buf_a[int'(step)*SW +: SW];
                        arr2 <= buf_b[int'(step)*SW +: SW];
                        step <= step + STEP_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain == '0) begin
                        state <= CAPTURE;
                    end else begin
                        drain <= drain - DRAIN_W'(1);
                    end
                end
                CAPTURE: begin
                    bus.res_row   <= row_in;
                    bus.res_col   <= col_in;
                    bus.res_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    // A start arriving alongside the handshake is dropped here on purpose.
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
